// File: rtl/fetch_pc_unit_if.sv
// Fetch request channel between the PC unit and the instruction memory controller.
// Latency: none, this is wiring only.
// Backpressure: the controller holds mem_req_ready low, and the requester then keeps its address.
interface fetch_pc_unit_if #(
  parameter int XLEN = 32
);
  logic            mem_req_valid;
  logic [XLEN-1:0] mem_req_addr;
  logic            mem_req_ready;

  modport master (
    output mem_req_valid,
    output mem_req_addr,
    input  mem_req_ready
  );

  modport slave (
    input  mem_req_valid,
    input  mem_req_addr,
    output mem_req_ready
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// Program counter with redirect, prediction, and nested interrupt entry/return; issues fetch requests.
// Latency: the selected next PC appears one cycle after the event, while flush and irq_ack are same-cycle combinational.
// Backpressure: with mem_req_ready low the PC holds, and only redirect, return or interrupt entry may move it.
module fetch_pc_unit #(
  parameter int              XLEN      = 32,
  parameter int              INC       = 4,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [XLEN-1:0] IRQ_VEC   = 'h0000_1000,
  parameter int              IRQ_DEPTH = 4,
  localparam int             DW        = $clog2(IRQ_DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            predict_valid,
  input  logic [XLEN-1:0] predict_pc,
  input  logic            irq_req,
  input  logic            irq_ret,
  input  logic            irq_unmask,
  fetch_pc_unit_if.master mem,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus_inc,
  output logic            flush,
  output logic            irq_ack,
  output logic            irq_mask,
  output logic [DW-1:0]   irq_depth,
  output logic            irq_full,
  output logic            irq_err
);

  // Stack index width. A one-entry stack still needs a 1-bit index.
  localparam int            IW        = (IRQ_DEPTH > 1) ? $clog2(IRQ_DEPTH) : 1;
  localparam logic [DW-1:0] ONE       = DW'(1);
  localparam logic [DW-1:0] DEPTH_MAX = DW'(IRQ_DEPTH);

  logic [XLEN-1:0] stack [IRQ_DEPTH];
  logic [XLEN-1:0] pc_nxt;
  logic [IW-1:0]   push_idx;
  logic [IW-1:0]   pop_idx;
  logic            fire;
  logic            ret_take;
  logic            irq_take;

  // While rst is high, no event may fire, so every event term is gated with !rst.
  assign mem.mem_req_valid = !rst && !stall;
  assign mem.mem_req_addr  = pc;
  assign fire              = mem.mem_req_valid && mem.mem_req_ready;

  assign pc_plus_inc = pc + XLEN'(INC);
  assign irq_full    = (irq_depth == DEPTH_MAX);

  // A return only pops a real frame, and a redirect in the same cycle cancels it.
  assign ret_take = !rst && irq_ret && (irq_depth != '0) && !redirect_valid;
  // Interrupt entry waits out stalls, redirects and returns, and is held off while the stack is full.
  assign irq_take = !rst && irq_req && !irq_mask && !irq_full && !stall
                    && !redirect_valid && !ret_take;

  assign flush   = !rst && (redirect_valid || ret_take || irq_take);
  assign irq_ack = irq_take;

  // A push only happens when the stack is not full, and a pop only when it is not empty, so both indices stay in range.
  assign push_idx = IW'(irq_depth);
  assign pop_idx  = IW'(irq_depth - ONE);

  // Next-PC select, in priority order: redirect, return, interrupt entry, predicted fetch, sequential fetch, hold.
  always_comb begin
    pc_nxt = pc;
    if (redirect_valid)
      pc_nxt = redirect_pc;
    else if (ret_take)
      pc_nxt = stack[pop_idx];
    else if (irq_take)
      pc_nxt = IRQ_VEC;
    else if (fire && predict_valid)
      pc_nxt = predict_pc;
    else if (fire)
      pc_nxt = pc_plus_inc;
  end

  // PC, stack occupancy, mask and sticky error. Entry setting the mask beats a same-cycle unmask.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc        <= RESET_PC;
      irq_depth <= '0;
      irq_mask  <= 1'b0;
      irq_err   <= 1'b0;
    end else begin
      pc <= pc_nxt;
      if (irq_take)
        irq_depth <= irq_depth + ONE;
      else if (ret_take)
        irq_depth <= irq_depth - ONE;
      if (irq_take)
        irq_mask <= 1'b1;
      else if (ret_take || irq_unmask)
        irq_mask <= 1'b0;
      if (irq_ret && (irq_depth == '0))
        irq_err <= 1'b1;
    end
  end

  // Return-address stack. The pushed address is the fetch being discarded, so it is re-fetched on return.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < IRQ_DEPTH; i++)
        stack[i] <= '0;
    end else if (irq_take) begin
      stack[push_idx] <= pc;
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit with a two-deep interrupt stack.
// Latency: directed vectors check next-PC one cycle after each event, and random traffic is checked every cycle against a queue model.
// Backpressure: mem_req_ready is toggled both by the vectors and at random.
module tb_fetch_pc_unit;

  localparam int          XLEN  = 32;
  localparam int          DEPTH = 2;
  localparam logic [31:0] VEC   = 32'h0000_1000;

  localparam logic [6:0] C_STALL = 7'b1000000;
  localparam logic [6:0] C_RV    = 7'b0100000;
  localparam logic [6:0] C_PV    = 7'b0010000;
  localparam logic [6:0] C_IRQ   = 7'b0001000;
  localparam logic [6:0] C_RET   = 7'b0000100;
  localparam logic [6:0] C_UNM   = 7'b0000010;
  localparam logic [6:0] C_RDY   = 7'b0000001;

  typedef struct {
    logic [6:0]  ctl;
    logic [31:0] rpc;
    logic [31:0] ppc;
    logic [1:0]  ev;      // {flush, irq_ack} expected in the event cycle
    logic [31:0] e_pc;
    logic [1:0]  e_depth;
    logic        e_mask;
    logic        e_err;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, redirect_valid, predict_valid, irq_req, irq_ret, irq_unmask;
  logic [31:0] redirect_pc, predict_pc;
  logic [31:0] pc, pc_plus_inc;
  logic        flush, irq_ack, irq_mask, irq_full, irq_err;
  logic [1:0]  irq_depth;

  int total = 0;
  int bad   = 0;

  fetch_pc_unit_if #(.XLEN(XLEN)) mem_if ();

  fetch_pc_unit #(
    .XLEN(XLEN), .INC(4), .RESET_PC(32'h0), .IRQ_VEC(VEC), .IRQ_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .predict_valid(predict_valid), .predict_pc(predict_pc),
    .irq_req(irq_req), .irq_ret(irq_ret), .irq_unmask(irq_unmask),
    .mem(mem_if),
    .pc(pc), .pc_plus_inc(pc_plus_inc), .flush(flush), .irq_ack(irq_ack),
    .irq_mask(irq_mask), .irq_depth(irq_depth), .irq_full(irq_full), .irq_err(irq_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [6:0] ctl, input logic [31:0] rpc, input logic [31:0] ppc);
    stall                = ctl[6];
    redirect_valid       = ctl[5];
    predict_valid        = ctl[4];
    irq_req              = ctl[3];
    irq_ret              = ctl[2];
    irq_unmask           = ctl[1];
    mem_if.mem_req_ready = ctl[0];
    redirect_pc          = rpc;
    predict_pc           = ppc;
  endtask

  // Behavioural reference: a queue of return addresses plus the PC, mask and error state.
  logic [31:0] m_stk[$];
  logic [31:0] m_pc;
  logic        m_mask, m_err;

  vec_t tv[28];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic m_fire, m_full, m_ret, m_irq;

    // Hand-counted stream: sequential, backpressure, predict, single irq, nesting, full, redirect, stray return, wrap.
    tv[0]  = '{C_RDY,                     32'h0,         32'h0,  2'b00, 32'h4,         2'd0, 1'b0, 1'b0};
    tv[1]  = '{C_RDY,                     32'h0,         32'h0,  2'b00, 32'h8,         2'd0, 1'b0, 1'b0};
    tv[2]  = '{C_RDY,                     32'h0,         32'h0,  2'b00, 32'hC,         2'd0, 1'b0, 1'b0};
    tv[3]  = '{C_RDY,                     32'h0,         32'h0,  2'b00, 32'h10,        2'd0, 1'b0, 1'b0};
    tv[4]  = '{7'b0,                      32'h0,         32'h0,  2'b00, 32'h10,        2'd0, 1'b0, 1'b0};
    tv[5]  = '{7'b0,                      32'h0,         32'h0,  2'b00, 32'h10,        2'd0, 1'b0, 1'b0};
    tv[6]  = '{7'b0,                      32'h0,         32'h0,  2'b00, 32'h10,        2'd0, 1'b0, 1'b0};
    tv[7]  = '{C_RDY,                     32'h0,         32'h0,  2'b00, 32'h14,        2'd0, 1'b0, 1'b0};
    tv[8]  = '{C_RDY|C_PV,                32'h0,         32'h80, 2'b00, 32'h80,        2'd0, 1'b0, 1'b0};
    tv[9]  = '{C_RDY|C_RV,                32'h20,        32'h0,  2'b10, 32'h20,        2'd0, 1'b0, 1'b0};
    tv[10] = '{C_RDY|C_IRQ,               32'h0,         32'h0,  2'b11, 32'h1000,      2'd1, 1'b1, 1'b0};
    tv[11] = '{C_RDY,                     32'h0,         32'h0,  2'b00, 32'h1004,      2'd1, 1'b1, 1'b0};
    tv[12] = '{C_RDY,                     32'h0,         32'h0,  2'b00, 32'h1008,      2'd1, 1'b1, 1'b0};
    tv[13] = '{C_RDY|C_RET,               32'h0,         32'h0,  2'b10, 32'h20,        2'd0, 1'b0, 1'b0};
    tv[14] = '{C_RDY|C_IRQ,               32'h0,         32'h0,  2'b11, 32'h1000,      2'd1, 1'b1, 1'b0};
    tv[15] = '{C_RDY|C_UNM,               32'h0,         32'h0,  2'b00, 32'h1004,      2'd1, 1'b0, 1'b0};
    tv[16] = '{C_RDY,                     32'h0,         32'h0,  2'b00, 32'h1008,      2'd1, 1'b0, 1'b0};
    tv[17] = '{C_RDY|C_IRQ,               32'h0,         32'h0,  2'b11, 32'h1000,      2'd2, 1'b1, 1'b0};
    tv[18] = '{C_RDY|C_IRQ|C_UNM,         32'h0,         32'h0,  2'b00, 32'h1004,      2'd2, 1'b0, 1'b0};
    tv[19] = '{C_RDY|C_IRQ,               32'h0,         32'h0,  2'b00, 32'h1008,      2'd2, 1'b0, 1'b0};
    tv[20] = '{C_STALL|C_RV|C_RET|C_IRQ,  32'h200,       32'h0,  2'b10, 32'h200,       2'd2, 1'b0, 1'b0};
    tv[21] = '{C_RDY|C_RET,               32'h0,         32'h0,  2'b10, 32'h1008,      2'd1, 1'b0, 1'b0};
    tv[22] = '{C_RDY|C_RET,               32'h0,         32'h0,  2'b10, 32'h20,        2'd0, 1'b0, 1'b0};
    tv[23] = '{C_STALL|C_IRQ|C_RDY,       32'h0,         32'h0,  2'b00, 32'h20,        2'd0, 1'b0, 1'b0};
    tv[24] = '{C_RDY|C_RET,               32'h0,         32'h0,  2'b00, 32'h24,        2'd0, 1'b0, 1'b1};
    tv[25] = '{C_RDY|C_RV,                32'hFFFF_FFF8, 32'h0,  2'b10, 32'hFFFF_FFF8, 2'd0, 1'b0, 1'b1};
    tv[26] = '{C_RDY,                     32'h0,         32'h0,  2'b00, 32'hFFFF_FFFC, 2'd0, 1'b0, 1'b1};
    tv[27] = '{C_RDY,                     32'h0,         32'h0,  2'b00, 32'h0,         2'd0, 1'b0, 1'b1};

    // Reset with events pending: nothing may fire, and every output sits at its reset value.
    rst = 1'b1;
    drive(C_RDY|C_IRQ|C_RV|C_RET, 32'h300, 32'h0);
    #12;
    chk("rst_pc",    pc, 32'h0);
    chk("rst_pinc",  pc_plus_inc, 32'h4);
    chk("rst_vld",   32'(mem_if.mem_req_valid), 32'h0);
    chk("rst_flush", 32'(flush), 32'h0);
    chk("rst_ack",   32'(irq_ack), 32'h0);
    chk("rst_depth", 32'(irq_depth), 32'h0);
    chk("rst_mask",  32'(irq_mask), 32'h0);
    chk("rst_err",   32'(irq_err), 32'h0);
    chk("rst_full",  32'(irq_full), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(C_STALL, 32'h0, 32'h0);

    for (int i = 0; i < 28; i++) begin
      @(negedge clk);
      drive(tv[i].ctl, tv[i].rpc, tv[i].ppc);
      #2;
      chk($sformatf("v%0d_flush", i), 32'(flush), 32'(tv[i].ev[1]));
      chk($sformatf("v%0d_ack", i),   32'(irq_ack), 32'(tv[i].ev[0]));
      chk($sformatf("v%0d_vld", i),   32'(mem_if.mem_req_valid), 32'(!tv[i].ctl[6]));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_pc", i),    pc, tv[i].e_pc);
      chk($sformatf("v%0d_addr", i),  mem_if.mem_req_addr, tv[i].e_pc);
      chk($sformatf("v%0d_depth", i), 32'(irq_depth), 32'(tv[i].e_depth));
      chk($sformatf("v%0d_full", i),  32'(irq_full), 32'(tv[i].e_depth == 2'd2));
      chk($sformatf("v%0d_mask", i),  32'(irq_mask), 32'(tv[i].e_mask));
      chk($sformatf("v%0d_err", i),   32'(irq_err), 32'(tv[i].e_err));
    end

    // Reset in the middle of a handler drops the frame and clears the sticky error immediately.
    @(negedge clk);
    drive(C_RDY|C_IRQ, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    chk("mid_pc_in",    pc, VEC);
    chk("mid_depth_in", 32'(irq_depth), 32'h1);
    #2;
    rst = 1'b1;
    drive(7'b0, 32'h0, 32'h0);
    #1;
    chk("mid_pc",    pc, 32'h0);
    chk("mid_depth", 32'(irq_depth), 32'h0);
    chk("mid_mask",  32'(irq_mask), 32'h0);
    chk("mid_err",   32'(irq_err), 32'h0);
    chk("mid_vld",   32'(mem_if.mem_req_valid), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(C_STALL, 32'h0, 32'h0);

    // Random traffic checked against the queue model.
    m_pc   = 32'h0;
    m_mask = 1'b0;
    m_err  = 1'b0;
    m_stk.delete();
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      stall                = ($urandom_range(0, 4) == 0);
      redirect_valid       = ($urandom_range(0, 15) == 0);
      redirect_pc          = $urandom() & 32'hFFFF_FFFC;
      predict_valid        = ($urandom_range(0, 3) == 0);
      predict_pc           = $urandom() & 32'hFFFF_FFFC;
      irq_req              = ($urandom_range(0, 3) == 0);
      irq_ret              = ($urandom_range(0, 7) == 0);
      irq_unmask           = ($urandom_range(0, 7) == 0);
      mem_if.mem_req_ready = ($urandom_range(0, 3) != 0);
      #2;
      m_fire = !stall && mem_if.mem_req_ready;
      m_full = (m_stk.size() == DEPTH);
      m_ret  = irq_ret && (m_stk.size() != 0) && !redirect_valid;
      m_irq  = irq_req && !m_mask && !m_full && !stall && !redirect_valid && !m_ret;
      chk("r_flush", 32'(flush), 32'(redirect_valid || m_ret || m_irq));
      chk("r_ack",   32'(irq_ack), 32'(m_irq));
      chk("r_vld",   32'(mem_if.mem_req_valid), 32'(!stall));
      chk("r_addr",  mem_if.mem_req_addr, m_pc);
      chk("r_pc",    pc, m_pc);
      chk("r_pinc",  pc_plus_inc, m_pc + 32'd4);
      chk("r_depth", 32'(irq_depth), 32'(m_stk.size()));
      chk("r_full",  32'(irq_full), 32'(m_full));
      chk("r_mask",  32'(irq_mask), 32'(m_mask));
      chk("r_err",   32'(irq_err), 32'(m_err));
      if (irq_ret && m_stk.size() == 0)
        m_err = 1'b1;
      if (m_irq)
        m_mask = 1'b1;
      else if (m_ret || irq_unmask)
        m_mask = 1'b0;
      if (redirect_valid) begin
        m_pc = redirect_pc;
      end else if (m_ret) begin
        m_pc = m_stk.pop_back();
      end else if (m_irq) begin
        m_stk.push_back(m_pc);
        m_pc = VEC;
      end else if (m_fire && predict_valid) begin
        m_pc = predict_pc;
      end else if (m_fire) begin
        m_pc = m_pc + 32'd4;
      end
      @(posedge clk);
    end
    #1;
    chk("r_final_pc", pc, m_pc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Parametrised program-counter and fetch-request unit for the front end of the CPU pipeline. It holds the PC and presents fetch addresses to the instruction memory controller over a valid/ready handshake. It selects the next PC from redirect, branch prediction, interrupt entry and interrupt return sources. A depth-configurable return-address stack allows nested interrupts. It sits ahead of the IF/ID buffer and reports flushes to the hazard unit.

## Interface
- XLEN, 32: PC / address width.
- INC, 4: byte increment per sequential fetch.
- RESET_PC, 0: PC value after reset.
- IRQ_VEC, 32'h0000_1000: interrupt handler entry address (XLEN bits).
- IRQ_DEPTH, 4: return-stack entries (≥1); sets the maximum nesting level.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  hazard-unit stall; holds sequential/predicted advance.
- redirect_valid  in  1  branch mispredict undo / resolved redirect.
- redirect_pc  in  XLEN  target for redirect.
- predict_valid  in  1  predictor says taken.
- predict_pc  in  XLEN  predicted target.
- irq_req  in  1  level interrupt request.
- irq_ret  in  1  return-from-interrupt pulse.
- irq_unmask  in  1  pulse; clears the mask inside a handler (enables nesting).
- mem_req_valid  out  1  fetch request valid.
- mem_req_addr  out  XLEN  fetch address (= pc).
- mem_req_ready  in  1  memory controller accepts the request.
- pc  out  XLEN  current PC register.
- pc_plus_inc  out  XLEN  pc + INC, wraps mod 2^XLEN.
- flush  out  1  younger fetched work is invalid (combinational).
- irq_ack  out  1  interrupt entry taken this cycle (combinational).
- irq_mask  out  1  interrupts blocked.
- irq_depth  out  $clog2(IRQ_DEPTH+1)  current stack occupancy.
- irq_full  out  1  irq_depth == IRQ_DEPTH.
- irq_err  out  1  sticky: irq_ret seen with empty stack.

## Operation
- Events:
  - fire = mem_req_valid & mem_req_ready.
  - irq_take = irq_req & !irq_mask & !irq_full & !stall & !redirect_valid & !ret_take.
  - ret_take = irq_ret & irq_depth≠0 & !redirect_valid.
- Next-PC priority, highest first:
  1. redirect_valid → redirect_pc.
  2. ret_take → top of stack; pop; irq_mask←0.
  3. irq_take → IRQ_VEC; push pc; irq_mask←1.
  4. fire & predict_valid → predict_pc.
  5. fire → pc_plus_inc.
  6. Otherwise hold.
- Redirect and return are honoured during stall and regardless of mem_req_ready. Interrupt entry waits for !stall.
- The pushed return address is the current pc, i.e. the unaccepted or just-accepted fetch. That fetch is discarded through flush and re-fetched on return.
- flush = redirect_valid | ret_take | irq_take.
- mem_req_valid = !stall. mem_req_addr = pc.
- irq_unmask clears irq_mask. An irq_take in the same cycle wins and sets the mask.
- irq_req while irq_full: held off, no push, no error. Entry is taken once a return frees a slot.
- irq_ret with depth 0: ignored (no PC change, no flush), irq_err←1 until reset.
- irq_ret together with redirect_valid: redirect wins and the stack is untouched. Software re-issues the return.
- Stack is a LIFO of IRQ_DEPTH × XLEN registers. Push and pop never occur in the same cycle.

## Timing
- Reset (async assert, output values immediate):
  - pc=RESET_PC, irq_depth=0, irq_mask=0, irq_err=0, stack contents 0.
  - flush=0, irq_ack=0 (no events while rst).
  - mem_req_valid=0 while rst is high.
- Reset mid-handler discards all stack frames.
- Next-PC latency is one cycle: the selected PC appears on pc / mem_req_addr the cycle after the event.
- flush and irq_ack are asserted in the event cycle only.
- A request held under !mem_req_ready keeps the same mem_req_addr until fire or redirect.
- irq_depth, irq_mask and irq_err update at the same edge as pc.

## Test plan
- Reset release, ready=1, no events → pc 0,4,8,12…; at pc=XLEN max−3 it wraps to 0.
- ready low 3 cycles at pc=0x10 → mem_req_addr stays 0x10, then 0x14 after fire. predict_valid with predict_pc=0x80 on fire → pc=0x80.
- irq_req at pc=0x20 → irq_ack=1, flush=1, next pc=0x1000, depth=1, mask=1. irq_ret → pc=0x20, depth=0, mask=0.
- Nesting, IRQ_DEPTH=2: irq at 0x20, unmask, irq at 0x1008, then a third irq → ignored while irq_full=1. Two returns → pc 0x1008, then 0x20.
- Redirect (0x200) with irq_ret and irq_req in the same cycle, stall=1 → pc=0x200, flush=1, depth unchanged, no irq_ack.
- irq_ret at depth 0 → pc advances normally, flush=0, irq_err=1 until rst. Assert rst mid-handler → depth=0, pc=RESET_PC immediately.
